mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Parametrised N-port arbiter that time-shares one single-ported unified memory among the pipeline's requesters (instruction fetch, load/store, and future ports such as a debug loader). It replaces clock-phase multiplexing of the memory with an explicit valid/ready request handshake, selectable fixed or round-robin priority, and a latency-matched response pipeline. It supports back-to-back issue and routes each response to its originating port. It sits between the pipeline's IF/MEM stages and the memory macro.

## Interface
- N_PORTS, 2: number of requesters; legal range 2..8.
- ADDR_W, 32: address width.
- DATA_W, 32: data width.
- MEM_LAT, 1: cycles from issue to read data valid on mem_rdata; legal range 1..4.
- RR_EN, 1: 1 selects round-robin priority; 0 selects fixed priority, with port 0 highest.

Ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous assert, active-low.
- req_valid  in  N_PORTS  per-port request.
- req_ready  out  N_PORTS  per-port grant; combinational.
- req_addr  in  N_PORTS*ADDR_W  port p occupies bits [p*ADDR_W +: ADDR_W].
- req_we  in  N_PORTS  1 = store, 0 = load.
- req_func  in  N_PORTS*3  RISC-V funct3 access size/sign.
- req_wdata  in  N_PORTS*DATA_W  store data.
- rsp_valid  out  N_PORTS  one-cycle response pulse.
- rsp_rdata  out  DATA_W  shared response data; meaningful only where rsp_valid is set.
- mem_en, mem_we  out  1  memory strobe and write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_func  out  3  access size/sign to memory.
- mem_wdata  out  DATA_W  write data to memory.
- mem_rdata  in  DATA_W  memory read data.
- busy  out  1  high while any response is in flight.

## Operation
- Each cycle, at most one request is granted.
  - req_ready is one-hot or zero.
  - A transfer occurs when req_valid[p] & req_ready[p].
- Fixed mode: the lowest-index valid port wins.
- Round-robin mode:
  - Search begins at pointer ptr.
  - After a grant to port g, ptr becomes g+1, wrapping from N_PORTS-1 to 0.
  - With no grant, ptr holds.
- Memory outputs are combinational from the winner:
  - mem_en = |req_valid.
  - mem_we, mem_addr, mem_func and mem_wdata carry the granted port's fields.
  - With no valid request, all memory outputs are 0.
- Response tracking:
  - A MEM_LAT-deep shift register holds {v, port, we} per issued transfer.
  - Stage MEM_LAT-1 drives rsp_valid[port] = v.
  - rsp_rdata = mem_rdata for loads; rsp_rdata = 0 for stores. Stores are acknowledged.
- Requesters hold all request fields stable while req_valid is high and req_ready is low. The arbiter never drops a valid request.
- busy = OR of all v bits in the tracker.

## Timing
- Grant is zero-cycle (same cycle as req_valid).
- A response arrives exactly MEM_LAT cycles after the accepting edge.
- Throughput is one transfer per cycle. Up to MEM_LAT transfers are in flight; the tracker never stalls.
- Reset values:
  - ptr = 0 and all tracker v = 0.
  - rsp_valid = 0 and busy = 0.
  - req_ready and the mem_* outputs follow the combinational rules above (0 while all req_valid are low).
- Reset asserted mid-operation: in-flight transfers are discarded and no responses are emitted for them. Memory side effects of stores already issued remain.
- Simultaneous events:
  - A response for port p and a new grant to port p in the same cycle are both legal.
  - A port may be granted on consecutive cycles only if it is the sole requester (round-robin) or the highest-priority requester (fixed).
- Starvation bound in round-robin mode: a continuously valid port is granted within N_PORTS cycles.

## Structure
- Package mem_arb_pkg:
  - funct3 encodings: LB=000, LH=001, LW=010, LBU=100, LHU=101; SB/SH/SW share codes 000/001/010.
  - PORT_W = $clog2(N_PORTS) helper.
  - Tracker entry typedef {v, port[PORT_W], we}.
- Sub-module rr_arbiter(N):
  - Inputs: req vector, ptr, mode.
  - Output: one-hot grant.
  - Combinational; ptr register lives in mem_arbiter.
- Top module: ptr register, tracker shift register, and the output muxes.

## Test plan
- Reset: rst low while all req_valid are high. Then req_ready=00, rsp_valid=00, busy=0 and mem_en=0 during reset and until the first edge after release with req_valid low.
- Single load, N_PORTS=2, MEM_LAT=2: port1 reads 0x40, memory returns 0xDEADBEEF. Then rsp_valid=10 exactly 2 cycles after acceptance with rsp_rdata=0xDEADBEEF, and busy is high for those 2 cycles.
- Round-robin contention, N_PORTS=3: all ports continuously valid for 6 cycles. Grants follow 0,1,2,0,1,2.
- Fixed mode: same stimulus as the round-robin case. Port 0 is granted every cycle; ports 1 and 2 are held stable and never ready.
- Back-to-back mix, MEM_LAT=1: port0 writes 0x55 to 0x10, next cycle port1 reads 0x10. Then rsp_valid=01 with rsp_rdata=0, followed by rsp_valid=10 with rsp_rdata=0x55.
- Mid-flight reset, MEM_LAT=3: assert rst one cycle after a load is accepted. No rsp_valid pulse appears for that load; ptr=0 after reset release.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared encodings and types for the unified-memory arbiter.
package mem_arb_pkg;

  localparam logic [2:0] F_LB  = 3'b000;
  localparam logic [2:0] F_LH  = 3'b001;
  localparam logic [2:0] F_LW  = 3'b010;
  localparam logic [2:0] F_LBU = 3'b100;
  localparam logic [2:0] F_LHU = 3'b101;
  localparam logic [2:0] F_SB  = 3'b000;
  localparam logic [2:0] F_SH  = 3'b001;
  localparam logic [2:0] F_SW  = 3'b010;

  // Port field sized for the largest legal configuration (8 ports).
  localparam int PORT_W_MAX = 3;

  function automatic int port_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef struct packed {
    logic                  v;
    logic [PORT_W_MAX-1:0] port;
    logic                  we;
  } trk_entry_t;

endpackage

// File: rtl/mem_arbiter_rr.sv
// Combinational one-hot arbiter: rotating search from ptr, or fixed from port 0.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int PW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  input  logic          mode,
  output logic [N-1:0]  grant
);

  int   base;
  logic found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    base  = mode ? int'(ptr) : 0;
    for (int i = 0; i < N; i++) begin
      for (int p = 0; p < N; p++) begin
        if (!found && req[p] && (p == ((base + i) % N))) begin
          grant[p] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// N-port valid/ready arbiter in front of a single-ported memory with a
// latency-matched tracker that routes each response back to its requester.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int N_PORTS = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1,
  parameter int RR_EN   = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_PORTS-1:0]        req_valid,
  output logic [N_PORTS-1:0]        req_ready,
  input  logic [N_PORTS*ADDR_W-1:0] req_addr,
  input  logic [N_PORTS-1:0]        req_we,
  input  logic [N_PORTS*3-1:0]      req_func,
  input  logic [N_PORTS*DATA_W-1:0] req_wdata,
  output logic [N_PORTS-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      mem_en,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [2:0]                mem_func,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic [DATA_W-1:0]         mem_rdata,
  output logic                      busy
);

  localparam int PORT_W = port_w(N_PORTS);

  logic [N_PORTS-1:0] valid_g;
  logic [N_PORTS-1:0] grant;
  logic [PORT_W-1:0]  ptr;
  logic [PORT_W-1:0]  gidx;
  logic               any_grant;
  trk_entry_t         trk [MEM_LAT];
  trk_entry_t         last;

  // No grants while reset is held: a transfer accepted then would be lost.
  assign valid_g = rst ? req_valid : '0;

  rr_arbiter #(.N(N_PORTS), .PW(PORT_W)) u_arb (
    .req   (valid_g),
    .ptr   (ptr),
    .mode  (RR_EN != 0),
    .grant (grant)
  );

  assign req_ready = grant;
  assign any_grant = |grant;
  assign mem_en    = |valid_g;

  always_comb begin
    gidx      = '0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_func  = '0;
    mem_wdata = '0;
    for (int p = 0; p < N_PORTS; p++) begin
      if (grant[p]) begin
        gidx      = PORT_W'(p);
        mem_we    = req_we[p];
        mem_addr  = req_addr[p*ADDR_W +: ADDR_W];
        mem_func  = req_func[p*3 +: 3];
        mem_wdata = req_wdata[p*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
    end else if (any_grant) begin
      ptr <= (gidx == PORT_W'(N_PORTS - 1)) ? '0 : gidx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < MEM_LAT; i++) trk[i] <= '0;
    end else begin
      trk[0] <= '{v: any_grant, port: PORT_W_MAX'(gidx), we: mem_we};
      for (int i = 1; i < MEM_LAT; i++) trk[i] <= trk[i-1];
    end
  end

  always_comb begin
    last      = trk[MEM_LAT-1];
    rsp_valid = '0;
    for (int p = 0; p < N_PORTS; p++) begin
      rsp_valid[p] = last.v && (last.port == PORT_W_MAX'(p));
    end
    rsp_rdata = (last.v && !last.we) ? mem_rdata : '0;
    busy      = 1'b0;
    for (int i = 0; i < MEM_LAT; i++) busy = busy | trk[i].v;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Two arbiters on shared requesters: A (round-robin, latency 2), B (fixed, latency 1).
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req_valid, req_we;
  logic [95:0] req_addr, req_wdata;
  logic [8:0]  req_func;

  logic [2:0]  rdy [2];
  logic [2:0]  rv [2];
  logic [31:0] rdata [2];
  logic        en [2];
  logic        mwe [2];
  logic [31:0] maddr [2];
  logic [2:0]  mfunc [2];
  logic [31:0] mwdata [2];
  logic [31:0] mrd [2];
  logic        busy [2];

  always #5 clk = ~clk;

  mem_arbiter #(.N_PORTS(3), .ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .RR_EN(1)) dut_a (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[0]), .req_addr(req_addr),
    .req_we(req_we), .req_func(req_func), .req_wdata(req_wdata), .rsp_valid(rv[0]),
    .rsp_rdata(rdata[0]), .mem_en(en[0]), .mem_we(mwe[0]), .mem_addr(maddr[0]),
    .mem_func(mfunc[0]), .mem_wdata(mwdata[0]), .mem_rdata(mrd[0]), .busy(busy[0])
  );

  mem_arbiter #(.N_PORTS(3), .ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .RR_EN(0)) dut_b (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[1]), .req_addr(req_addr),
    .req_we(req_we), .req_func(req_func), .req_wdata(req_wdata), .rsp_valid(rv[1]),
    .rsp_rdata(rdata[1]), .mem_en(en[1]), .mem_we(mwe[1]), .mem_addr(maddr[1]),
    .mem_func(mfunc[1]), .mem_wdata(mwdata[1]), .mem_rdata(mrd[1]), .busy(busy[1])
  );

  function automatic logic [31:0] init_val(input logic [7:0] a);
    return (a == 8'h40) ? 32'hDEADBEEF : ({4{a}} ^ 32'h5A5A_0000);
  endfunction

  // Memory macros: latency 2 for A, latency 1 for B.
  for (genvar d = 0; d < 2; d++) begin : g_dev
    logic [31:0]  mem [256];
    logic [255:0] wr = '0;
    logic [31:0]  pipe [2];
    always @(posedge clk) begin
      if (en[d] && mwe[d]) begin
        mem[maddr[d][7:0]] <= mwdata[d];
        wr[maddr[d][7:0]]  <= 1'b1;
      end
      pipe[0] <= wr[maddr[d][7:0]] ? mem[maddr[d][7:0]] : init_val(maddr[d][7:0]);
      pipe[1] <= pipe[0];
    end
    assign mrd[d] = (d == 0) ? pipe[1] : pipe[0];
  end

  // Reference model: memory image, rotation pointer, queue of due responses.
  typedef struct {
    int          due;
    int          port;
    logic [31:0] data;
  } exp_t;

  exp_t        expq [2][$];
  logic [31:0] refm [2][256];
  bit          refw [2][256];
  int          mptr [2];
  int          lat [2] = '{2, 1};
  int          edges = 0;
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    logic [2:0] v;
    logic [2:0] ra;
    logic [2:0] rb;
  } vec_t;
  vec_t tv [12];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic int exp_grant(input logic [2:0] v, input int ptr, input bit rr);
    int base = rr ? ptr : 0;
    for (int i = 0; i < 3; i++) if (v[(base + i) % 3]) return (base + i) % 3;
    return -1;
  endfunction

  function automatic logic [31:0] ref_rd(input int d, input logic [7:0] a);
    return refw[d][a] ? refm[d][a] : init_val(a);
  endfunction

  // Called with inputs settled mid-cycle; checks both DUTs, then crosses one edge.
  task automatic step();
    int gs [2];
    for (int d = 0; d < 2; d++) begin
      int gr;
      logic [2:0] erv;
      logic [31:0] edat;
      exp_t e;
      gr = exp_grant(req_valid, mptr[d], d == 0);
      chk($sformatf("ready_%0d", d), rdy[d], (gr < 0) ? 3'b000 : 3'(1 << gr));
      chk($sformatf("mem_en_%0d", d), en[d], |req_valid);
      if (gr >= 0) begin
        chk($sformatf("mem_addr_%0d", d), maddr[d], req_addr[gr*32 +: 32]);
        chk($sformatf("mem_we_%0d", d), mwe[d], req_we[gr]);
        chk($sformatf("mem_func_%0d", d), mfunc[d], req_func[gr*3 +: 3]);
        chk($sformatf("mem_wdata_%0d", d), mwdata[d], req_wdata[gr*32 +: 32]);
      end else begin
        chk($sformatf("mem_idle_%0d", d), {maddr[d], mwdata[d], mfunc[d], mwe[d]}, 0);
      end
      erv  = 3'b000;
      edat = '0;
      if (expq[d].size() > 0 && expq[d][0].due == edges) begin
        e    = expq[d].pop_front();
        erv  = 3'(1 << e.port);
        edat = e.data;
      end
      chk($sformatf("rsp_valid_%0d", d), rv[d], erv);
      if (erv != 0) chk($sformatf("rsp_rdata_%0d", d), rdata[d], edat);
      chk($sformatf("busy_%0d", d), busy[d], (erv != 0) || (expq[d].size() > 0));
      gs[d] = gr;
    end
    @(posedge clk);
    edges++;
    for (int d = 0; d < 2; d++) begin
      if (gs[d] >= 0) begin
        int g;
        logic [7:0] a;
        exp_t e;
        g      = gs[d];
        a      = req_addr[g*32 +: 8];
        e.due  = edges + lat[d] - 1;
        e.port = g;
        e.data = req_we[g] ? 32'h0 : ref_rd(d, a);
        if (req_we[g]) begin
          refm[d][a] = req_wdata[g*32 +: 32];
          refw[d][a] = 1'b1;
        end
        expq[d].push_back(e);
        mptr[d] = (g + 1) % 3;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    req_valid = 3'b000;
    for (int i = 0; i < n; i++) begin
      #1;
      step();
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s_ready_%0d", tag, d), rdy[d], 3'b000);
      chk($sformatf("%s_rsp_%0d", tag, d), rv[d], 3'b000);
      chk($sformatf("%s_busy_%0d", tag, d), busy[d], 1'b0);
      chk($sformatf("%s_mem_en_%0d", tag, d), en[d], 1'b0);
    end
  endtask

  task automatic reset_mid();
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      mptr[d] = 0;
      expq[d].delete();
    end
    #1;
    chk_reset_outputs("midrst");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      mptr[d] = 0;
      for (int i = 0; i < 256; i++) refw[d][i] = 1'b0;
    end
    rst       = 1'b0;
    req_valid = 3'b111;
    req_we    = 3'b000;
    req_func  = {3'b010, 3'b010, 3'b010};
    req_addr  = {32'h22, 32'h21, 32'h20};
    req_wdata = {32'h3, 32'h2, 32'h1};
    #1;
    chk_reset_outputs("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    req_valid = 3'b000;
    rst       = 1'b1;
    #1;
    chk_reset_outputs("release");
    step();

    // Contention: A rotates 0,1,2,0,1,2; B stays on port 0.
    tv[0]  = '{3'b111, 3'b001, 3'b001};
    tv[1]  = '{3'b111, 3'b010, 3'b001};
    tv[2]  = '{3'b111, 3'b100, 3'b001};
    tv[3]  = '{3'b111, 3'b001, 3'b001};
    tv[4]  = '{3'b111, 3'b010, 3'b001};
    tv[5]  = '{3'b111, 3'b100, 3'b001};
    tv[6]  = '{3'b110, 3'b010, 3'b010};
    tv[7]  = '{3'b011, 3'b001, 3'b001};
    tv[8]  = '{3'b000, 3'b000, 3'b000};
    tv[9]  = '{3'b101, 3'b100, 3'b001};
    tv[10] = '{3'b100, 3'b100, 3'b100};
    tv[11] = '{3'b100, 3'b100, 3'b100};
    for (int i = 0; i < 12; i++) begin
      req_valid = tv[i].v;
      #1;
      chk($sformatf("tbl_a_%0d", i), rdy[0], tv[i].ra);
      chk($sformatf("tbl_b_%0d", i), rdy[1], tv[i].rb);
      step();
    end
    idle(3);

    // Single load from port 1 through A (latency 2).
    req_valid = 3'b010;
    req_addr  = {32'h0, 32'h40, 32'h0};
    #1;
    step();
    req_valid = 3'b000;
    #1;
    chk("load_busy1", busy[0], 1'b1);
    chk("load_early", rv[0], 3'b000);
    step();
    #1;
    chk("load_rsp", rv[0], 3'b010);
    chk("load_data", rdata[0], 32'hDEADBEEF);
    chk("load_busy2", busy[0], 1'b1);
    step();
    #1;
    chk("load_after", rv[0], 3'b000);
    chk("load_idle", busy[0], 1'b0);
    idle(2);

    // Store then dependent load back to back, checked on B (latency 1).
    req_valid = 3'b001;
    req_we    = 3'b001;
    req_addr  = {32'h0, 32'h0, 32'h10};
    req_wdata = {32'h0, 32'h0, 32'h55};
    #1;
    step();
    req_valid = 3'b010;
    req_we    = 3'b000;
    req_addr  = {32'h0, 32'h10, 32'h0};
    #1;
    chk("b2b_st_rsp", rv[1], 3'b001);
    chk("b2b_st_data", rdata[1], 32'h0);
    step();
    req_valid = 3'b000;
    #1;
    chk("b2b_ld_rsp", rv[1], 3'b010);
    chk("b2b_ld_data", rdata[1], 32'h55);
    step();
    idle(3);

    // Reset one cycle after a load is accepted: its response must vanish.
    req_valid = 3'b001;
    req_addr  = {32'h0, 32'h0, 32'h30};
    #1;
    step();
    req_valid = 3'b000;
    reset_mid();
    req_valid = 3'b111;
    #1;
    chk("ptr_after_reset", rdy[0], 3'b001);
    step();
    idle(3);

    for (int i = 0; i < 400; i++) begin
      req_valid = 3'($urandom);
      req_we    = 3'($urandom);
      req_func  = 9'($urandom);
      for (int p = 0; p < 3; p++) begin
        req_addr[p*32 +: 32]  = 32'($urandom_range(0, 15));
        req_wdata[p*32 +: 32] = $urandom;
      end
      #1;
      step();
    end
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
